execute_stage: RTL

- EX stage of the five-stage MIPS pipeline; consumes the ID/EX register fields, applies operand forwarding, performs the ALU operation and branch/JR resolution, and owns the EX/MEM pipeline register.
- Sits between the ID/EX register and the memory stage.
- Redirect outputs go to the fetch/hazard logic.

---
 rtl/cpu_types_pkg.sv | 46 ++++
 rtl/exmem_pipelineReg_if.sv | 28 ++
 rtl/ex_forward_unit.sv | 37 +++
 rtl/execute_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared MIPS datapath types: opcodes, ALU operations, operand-B source encodings
// and the execute-stage forward-hold state.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int IMM_W  = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [4:0]        regbits_t;

   typedef enum logic [5:0] {
      RTYPE = 6'h00,
      J     = 6'h02,
      JAL   = 6'h03,
      BEQ   = 6'h04,
      BNE   = 6'h05,
      ADDI  = 6'h08,
      ADDIU = 6'h09,
      SLTI  = 6'h0a,
      SLTIU = 6'h0b,
      ANDI  = 6'h0c,
      ORI   = 6'h0d,
      XORI  = 6'h0e,
      LUI   = 6'h0f,
      LW    = 6'h23,
      SW    = 6'h2b,
      HALT  = 6'h3f
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   } aluop_t;

   localparam logic [1:0] ASRC_RT    = 2'd0;
   localparam logic [1:0] ASRC_IMM   = 2'd1;
   localparam logic [1:0] ASRC_SHAMT = 2'd2;
   localparam logic [1:0] ASRC_LUI   = 2'd3;

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} fwdstate_t;

   function automatic word_t signExt(input logic [IMM_W-1:0] imm);
      return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/exmem_pipelineReg_if.sv
// EX/MEM pipeline register bundle. The execute stage drives it (master);
// the memory stage and hazard logic observe it (slave).
interface exmem_pipelineReg_if;
   import cpu_types_pkg::*;

   word_t    aluOut;
   word_t    storeData;
   word_t    pc_add4;
   word_t    instruction;
   regbits_t wsel;
   logic     regWr;
   logic     memToReg;
   logic     dREN;
   logic     dWEN;
   logic     halt;
   opcode_t  opCode;

   modport master (
      output aluOut, storeData, pc_add4, instruction, wsel,
             regWr, memToReg, dREN, dWEN, halt, opCode
   );

   modport slave (
      input aluOut, storeData, pc_add4, instruction, wsel,
            regWr, memToReg, dREN, dWEN, halt, opCode
   );

endinterface

// File: rtl/ex_forward_unit.sv
// Combinational operand forwarding for rs/rt: EX/MEM result first, then MEM/WB
// writeback data, else the register-file value. $0 is never forwarded.
module ex_forward_unit
   import cpu_types_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  regbits_t rs,
   input  regbits_t rt,
   input  word_t    rdat1,
   input  word_t    rdat2,
   input  logic     exmemRegWr,
   input  logic     exmemMemToReg,
   input  regbits_t exmemWsel,
   input  word_t    exmemAluOut,
   input  logic     memwbRegWr,
   input  regbits_t memwbWsel,
   input  word_t    memwbWdat,
   output word_t    fwdA,
   output word_t    fwdB
);

   // A load's EX/MEM aluOut is an address, not the loaded value, so it is skipped.
   always_comb begin
      fwdA = rdat1;
      fwdB = rdat2;
      if (FWD_EN && rs != '0) begin
         if (exmemRegWr && !exmemMemToReg && exmemWsel == rs) fwdA = exmemAluOut;
         else if (memwbRegWr && memwbWsel == rs)              fwdA = memwbWdat;
      end
      if (FWD_EN && rt != '0) begin
         if (exmemRegWr && !exmemMemToReg && exmemWsel == rt) fwdB = exmemAluOut;
         else if (memwbRegWr && memwbWsel == rt)              fwdB = memwbWdat;
      end
   end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding, ALU, branch/JR resolution and the EX/MEM register.
// A small hold FSM freezes forwarded operands while the memory stage stalls EX.
module execute_stage
   import cpu_types_pkg::*;
#(
   parameter bit       FWD_EN   = 1'b1,
   parameter regbits_t LINK_REG = 5'd31
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  word_t                idex_pc_add4,
   input  word_t                idex_instruction,
   input  word_t                idex_rdat1,
   input  word_t                idex_rdat2,
   input  logic                 idex_halt,
   input  logic                 idex_dREN,
   input  logic                 idex_dWEN,
   input  logic                 idex_extOp,
   input  logic                 idex_regWr,
   input  logic                 idex_memToReg,
   input  logic                 idex_isJRFlag,
   input  logic [IMM_W-1:0]     idex_immediate,
   input  logic [1:0]           idex_aluSrc,
   input  opcode_t              idex_opCode,
   input  aluop_t               idex_aluOp,
   input  regbits_t             idex_rs,
   input  regbits_t             idex_rt,
   input  regbits_t             idex_rd,
   input  word_t                idex_shamt,
   input  logic                 ex_stall,
   input  logic                 ex_flush,
   input  logic                 memwb_regWr,
   input  regbits_t             memwb_wsel,
   input  word_t                memwb_wdat,
   exmem_pipelineReg_if.master  exmem,
   output logic                 br_taken,
   output word_t                br_target,
   output fwdstate_t            fwdState
);

   fwdstate_t state, stateNext;
   logic      latchEn;
   word_t     fwdA, fwdB, holdA, holdB, rsVal, rtVal;
   word_t     opA, opB, immExt, aluRes;
   regbits_t  wselNext;

   ex_forward_unit #(.FWD_EN(FWD_EN)) uFwd (
      .rs            (idex_rs),
      .rt            (idex_rt),
      .rdat1         (idex_rdat1),
      .rdat2         (idex_rdat2),
      .exmemRegWr    (exmem.regWr),
      .exmemMemToReg (exmem.memToReg),
      .exmemWsel     (exmem.wsel),
      .exmemAluOut   (exmem.aluOut),
      .memwbRegWr    (memwb_regWr),
      .memwbWsel     (memwb_wsel),
      .memwbWdat     (memwb_wdat),
      .fwdA          (fwdA),
      .fwdB          (fwdB)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      latchEn   = 1'b0;
      case (state)
         RUN:  if (ex_stall && !ex_flush) begin
                  stateNext = HOLD;
                  latchEn   = 1'b1;
               end
         HOLD: if (!ex_stall || ex_flush) stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   assign fwdState = state;

   // Captured on entry to HOLD so WB can retire past us while EX waits.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         holdA <= '0;
         holdB <= '0;
      end else if (latchEn) begin
         holdA <= fwdA;
         holdB <= fwdB;
      end
   end

   always_comb begin
      rsVal  = (state == HOLD) ? holdA : fwdA;
      rtVal  = (state == HOLD) ? holdB : fwdB;
      immExt = idex_extOp ? signExt(idex_immediate)
                          : {{(WORD_W-IMM_W){1'b0}}, idex_immediate};
      opA    = rsVal;
      opB    = rtVal;
      case (idex_aluSrc)
         ASRC_IMM:   opB = immExt;
         ASRC_SHAMT: begin
            opA = rtVal;
            opB = idex_shamt;
         end
         ASRC_LUI:   opB = {idex_immediate, {(WORD_W-IMM_W){1'b0}}};
         default:    opB = rtVal;
      endcase
   end

   always_comb begin
      aluRes = '0;
      case (idex_aluOp)
         ALU_SLL:  aluRes = opA << opB[4:0];
         ALU_SRL:  aluRes = opA >> opB[4:0];
         ALU_ADD:  aluRes = opA + opB;
         ALU_SUB:  aluRes = opA - opB;
         ALU_AND:  aluRes = opA & opB;
         ALU_OR:   aluRes = opA | opB;
         ALU_XOR:  aluRes = opA ^ opB;
         ALU_NOR:  aluRes = ~(opA | opB);
         ALU_SLT:  aluRes = {{(WORD_W-1){1'b0}}, $signed(opA) < $signed(opB)};
         ALU_SLTU: aluRes = {{(WORD_W-1){1'b0}}, opA < opB};
         default:  aluRes = '0;
      endcase
   end

   always_comb begin
      wselNext = idex_rt;
      if (idex_opCode == RTYPE)    wselNext = idex_rd;
      else if (idex_opCode == JAL) wselNext = LINK_REG;
   end

   always_comb begin
      br_taken  = 1'b0;
      br_target = idex_pc_add4 + (signExt(idex_immediate) << 2);
      if (idex_isJRFlag) begin
         br_taken  = 1'b1;
         br_target = rsVal;
      end else if (idex_opCode == BEQ) begin
         br_taken = (rsVal == rtVal);
      end else if (idex_opCode == BNE) begin
         br_taken = (rsVal != rtVal);
      end
      if (ex_stall) br_taken = 1'b0;
   end

   // Flush has priority over stall; halt stays set until flushed or reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         exmem.aluOut      <= '0;
         exmem.storeData   <= '0;
         exmem.pc_add4     <= '0;
         exmem.instruction <= '0;
         exmem.wsel        <= '0;
         exmem.regWr       <= 1'b0;
         exmem.memToReg    <= 1'b0;
         exmem.dREN        <= 1'b0;
         exmem.dWEN        <= 1'b0;
         exmem.halt        <= 1'b0;
         exmem.opCode      <= RTYPE;
      end else if (ex_flush) begin
         exmem.aluOut      <= '0;
         exmem.storeData   <= '0;
         exmem.pc_add4     <= '0;
         exmem.instruction <= '0;
         exmem.wsel        <= '0;
         exmem.regWr       <= 1'b0;
         exmem.memToReg    <= 1'b0;
         exmem.dREN        <= 1'b0;
         exmem.dWEN        <= 1'b0;
         exmem.halt        <= 1'b0;
         exmem.opCode      <= RTYPE;
      end else if (!ex_stall) begin
         exmem.aluOut      <= (idex_opCode == JAL) ? idex_pc_add4 : aluRes;
         exmem.storeData   <= rtVal;
         exmem.pc_add4     <= idex_pc_add4;
         exmem.instruction <= idex_instruction;
         exmem.wsel        <= wselNext;
         exmem.regWr       <= idex_regWr;
         exmem.memToReg    <= idex_memToReg;
         exmem.dREN        <= idex_dREN;
         exmem.dWEN        <= idex_dWEN;
         exmem.halt        <= exmem.halt | idex_halt;
         exmem.opCode      <= idex_opCode;
      end
   end

endmodule
